troco_dispenser: RTL and testbench

- Change/coin-return engine for the vending machine; the outbound counterpart of coin intake: converts the credit balance back into physical coins.
- On a start pulse it captures the current saldo and ejects coins greedily, larger coin first, one at a time.
- Each coin uses a request/acknowledge handshake with the coin mechanism.
- Reports the amount actually returned so balance control can debit it, and keeps per-type coin stock counters.

---
 rtl/troco_dispenser.sv | 185 ++++++++++++++++++
 tb/tb_troco_dispenser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/troco_dispenser.sv
// Change-return engine: turns the captured balance into coins, largest first, one per handshake.
// Optional thermometer output ledTroco is enabled by defining TROCO_LED_EN.
module troco_dispenser #(
  parameter int unsigned VAL_U       = 2,
  parameter int unsigned VAL_C       = 1,
  parameter int unsigned STOCK_INIT  = 20,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] saldoIn,
  input  logic       coin_ack,
  input  logic       refill_u,
  input  logic       refill_c,
  output logic       eject_u,
  output logic       eject_c,
  output logic       busy,
  output logic       done,
  output logic [5:0] trocoOut,
  output logic       falta,
  output logic       erro,
  output logic [5:0] stock_u,
`ifdef TROCO_LED_EN
  output logic [9:0] ledTroco,
`endif
  output logic [5:0] stock_c
);

  localparam int unsigned W       = 6;
  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [W-1:0]     VU        = W'(VAL_U);
  localparam logic [W-1:0]     VC        = W'(VAL_C);
  localparam logic [W-1:0]     SI        = W'(STOCK_INIT);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEL, WAIT, GAP, FINISH} state_t;

  state_t           state, state_d;
  logic [W-1:0]     rem, rem_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sel_u, sel_u_d;
  logic             eject_u_d, eject_c_d, busy_d, done_d, falta_d, erro_d;
  logic [W-1:0]     troco_d, stock_u_d, stock_c_d;

  // State register and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      cnt      <= '0;
      sel_u    <= 1'b0;
      eject_u  <= 1'b0;
      eject_c  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      trocoOut <= '0;
      falta    <= 1'b0;
      erro     <= 1'b0;
      stock_u  <= SI;
      stock_c  <= SI;
    end else begin
      state    <= state_d;
      rem      <= rem_d;
      cnt      <= cnt_d;
      sel_u    <= sel_u_d;
      eject_u  <= eject_u_d;
      eject_c  <= eject_c_d;
      busy     <= busy_d;
      done     <= done_d;
      trocoOut <= troco_d;
      falta    <= falta_d;
      erro     <= erro_d;
      stock_u  <= stock_u_d;
      stock_c  <= stock_c_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    rem_d     = rem;
    cnt_d     = cnt;
    sel_u_d   = sel_u;
    eject_u_d = eject_u;
    eject_c_d = eject_c;
    busy_d    = busy;
    done_d    = 1'b0;
    troco_d   = trocoOut;
    falta_d   = falta;
    erro_d    = erro;
    stock_u_d = stock_u;
    stock_c_d = stock_c;

    case (state)
      IDLE: begin
        if (start && !erro) begin
          rem_d   = saldoIn;
          troco_d = '0;
          falta_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        cnt_d = '0;
        if (rem >= VU && stock_u != '0) begin
          eject_u_d = 1'b1;
          sel_u_d   = 1'b1;
          state_d   = WAIT;
        end else if (rem >= VC && stock_c != '0) begin
          eject_c_d = 1'b1;
          sel_u_d   = 1'b0;
          state_d   = WAIT;
        end else begin
          done_d  = 1'b1;
          falta_d = (rem != '0);
          state_d = FINISH;
        end
      end
      WAIT: begin
        if (coin_ack) begin
          eject_u_d = 1'b0;
          eject_c_d = 1'b0;
          cnt_d     = '0;
          state_d   = GAP;
          if (sel_u) begin
            rem_d     = rem - VU;
            troco_d   = trocoOut + VU;
            stock_u_d = stock_u - W'(1);
          end else begin
            rem_d     = rem - VC;
            troco_d   = trocoOut + VC;
            stock_c_d = stock_c - W'(1);
          end
        end else if (cnt >= WAIT_LAST) begin
          // Mechanism never answered: abandon this coin without debiting it
          eject_u_d = 1'b0;
          eject_c_d = 1'b0;
          erro_d    = 1'b1;
          done_d    = 1'b1;
          falta_d   = (rem != '0);
          state_d   = FINISH;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) state_d = SEL;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Refill overrides any same-cycle decrement
    if (refill_u) stock_u_d = SI;
    if (refill_c) stock_c_d = SI;
  end

`ifdef TROCO_LED_EN
  logic [9:0] led_d;

  // Thermometer of the remaining balance, saturating at 10
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 10; i++) begin
      led_d[i] = busy_d && (rem_d > W'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ledTroco <= '0;
    else       ledTroco <= led_d;
  end
`endif

endmodule

// File: tb/tb_troco_dispenser.sv
// Randomized self-checking bench for troco_dispenser against a greedy change model.
module tb_troco_dispenser;

  localparam int GAP_CYC     = 4;
  localparam int ACK_TIMEOUT = 1000;
  localparam int STOCK_INIT  = 20;
  localparam int BUDGET      = 5000;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] saldoIn;
  logic       coin_ack;
  logic       refill_u;
  logic       refill_c;
  logic       eject_u, eject_c, busy, done, falta, erro;
  logic [5:0] trocoOut, stock_u, stock_c;

  troco_dispenser dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .saldoIn  (saldoIn),
    .coin_ack (coin_ack),
    .refill_u (refill_u),
    .refill_c (refill_c),
    .eject_u  (eject_u),
    .eject_c  (eject_c),
    .busy     (busy),
    .done     (done),
    .trocoOut (trocoOut),
    .falta    (falta),
    .erro     (erro),
    .stock_u  (stock_u),
    .stock_c  (stock_c)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int m_su = STOCK_INIT;
  int m_sc = STOCK_INIT;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic refill(input bit u, input bit c);
    @(negedge clock);
    refill_u = u;
    refill_c = c;
    @(negedge clock);
    refill_u = 1'b0;
    refill_c = 1'b0;
    if (u) m_su = STOCK_INIT;
    if (c) m_sc = STOCK_INIT;
  endtask

  // One change operation; the model says how many coins of each type must come out
  task automatic run_op(input string tag, input int saldo, input int ack_dly,
                        input bit refill_on_c_ack, input bit spurious, output int lat);
    int  exp_nu, exp_nc, exp_rem, obs_nu, obs_nc, hi, lo, min_gap, order_bad, overlap;
    bit  prev, got_done, c_seen, cur_u;
    exp_nu  = min2(saldo / 2, m_su);
    exp_rem = saldo - 2 * exp_nu;
    exp_nc  = min2(exp_rem, m_sc);
    exp_rem = exp_rem - exp_nc;
    obs_nu = 0; obs_nc = 0; hi = 0; lo = 0; min_gap = 99; order_bad = 0; overlap = 0;
    prev = 0; got_done = 0; c_seen = 0; cur_u = 0; lat = -1;

    @(negedge clock);
    start   = 1'b1;
    saldoIn = 6'(saldo);
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clock);
      start    = 1'b0;
      coin_ack = 1'b0;
      refill_c = 1'b0;
      if (done) begin
        got_done = 1;
        lat = cyc;
        break;
      end
      if (eject_u && eject_c) overlap++;
      if (eject_u || eject_c) begin
        if (!prev) begin
          cur_u = eject_u;
          if (obs_nu + obs_nc > 0) min_gap = min2(min_gap, lo);
          if (eject_u) begin
            obs_nu++;
            if (c_seen) order_bad++;
          end else begin
            obs_nc++;
            c_seen = 1;
          end
          hi = 0;
        end
        hi++;
        if (hi == ack_dly) begin
          coin_ack = 1'b1;
          if (refill_on_c_ack && !cur_u) refill_c = 1'b1;
        end
        prev = 1;
      end else begin
        if (prev) lo = 0;
        lo++;
        prev = 0;
        if (spurious && $urandom_range(0, 5) == 0) coin_ack = 1'b1;
      end
    end
    coin_ack = 1'b0;
    refill_c = 1'b0;

    m_su = m_su - exp_nu;
    m_sc = refill_on_c_ack ? STOCK_INIT : m_sc - exp_nc;

    check({tag, "_done"}, int'(got_done), 1);
    check({tag, "_n_u"}, obs_nu, exp_nu);
    check({tag, "_n_c"}, obs_nc, exp_nc);
    check({tag, "_order"}, order_bad, 0);
    check({tag, "_onehot"}, overlap, 0);
    if (exp_nu + exp_nc >= 2) check({tag, "_gap_ok"}, int'(min_gap >= GAP_CYC), 1);
    check({tag, "_troco"}, int'(trocoOut), saldo - exp_rem);
    check({tag, "_falta"}, int'(falta), int'(exp_rem != 0));
    check({tag, "_stock_u"}, int'(stock_u), m_su);
    check({tag, "_stock_c"}, int'(stock_c), m_sc);
    check({tag, "_erro"}, int'(erro), 0);
    @(negedge clock);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int  lat, hi, seen;
    bit  got;
    reset = 1'b1; start = 1'b0; saldoIn = '0; coin_ack = 1'b0;
    refill_u = 1'b0; refill_c = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_eject_u", int'(eject_u), 0);
    check("rst_eject_c", int'(eject_c), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_troco", int'(trocoOut), 0);
    check("rst_falta", int'(falta), 0);
    check("rst_erro", int'(erro), 0);
    check("rst_stock_u", int'(stock_u), STOCK_INIT);
    check("rst_stock_c", int'(stock_c), STOCK_INIT);
    reset = 1'b0;

    run_op("zero", 0, 2, 0, 0, lat);
    check("zero_latency", lat, 2);
    run_op("seven", 7, 3, 0, 0, lat);
    run_op("drain", 63, 2, 0, 0, lat);
    refill(0, 1);
    run_op("c_only", 5, 3, 0, 0, lat);
    refill(1, 0);
    run_op("u_nostock_c", 5, 1, 0, 0, lat);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) refill(1, 0);
      if ($urandom_range(0, 3) == 0) refill(0, 1);
      run_op("rand", int'($urandom_range(0, 63)), int'($urandom_range(1, 6)), 0, 1, lat);
    end

    refill(1, 1);
    run_op("refill_on_ack", 1, 2, 1, 0, lat);

    // Reset while a coin request is outstanding
    @(negedge clock);
    start = 1'b1;
    saldoIn = 6'd4;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (eject_u) begin
        got = 1;
        break;
      end
    end
    check("mid_eject_seen", int'(got), 1);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_eject_u", int'(eject_u), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_stock_u", int'(stock_u), STOCK_INIT);
    check("mid_rst_stock_c", int'(stock_c), STOCK_INIT);
    @(negedge clock);
    reset = 1'b0;
    m_su = STOCK_INIT;
    m_sc = STOCK_INIT;

    // No acknowledge ever: timeout, sticky error, later starts ignored
    @(negedge clock);
    start = 1'b1;
    saldoIn = 6'd3;
    hi = 0;
    got = 0;
    for (int cyc = 1; cyc <= 3 * ACK_TIMEOUT; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
      if (eject_u) hi++;
    end
    check("to_done", int'(got), 1);
    check("to_hold", hi, ACK_TIMEOUT);
    check("to_eject_low", int'(eject_u), 0);
    check("to_erro", int'(erro), 1);
    check("to_troco", int'(trocoOut), 0);
    check("to_falta", int'(falta), 1);
    check("to_stock_u", int'(stock_u), m_su);
    @(negedge clock);
    start = 1'b1;
    saldoIn = 6'd5;
    seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy || eject_u || eject_c || done) seen++;
    end
    check("erro_blocks_start", seen, 0);
    check("erro_sticky", int'(erro), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
